// File: rtl/heartbeat_pulse_gen.sv
// heartbeat_pulse_gen: turns the 2-bit heartbeat code from the emotion model
// into a "lub-dub" waveform paced by a prescaled tick enable.
//
// Beat shape, in ticks:  LUB (high) -> GAP (low) -> DUB (high) -> REST (low).
// The LUB-to-LUB spacing equals the period selected by the code latched at LUB
// entry, so a code change mid-beat only takes effect at the next beat.
//
// Optional feature macro: HEARTBEAT_FLATLINE_EN
//   When defined, code 3 means "flatline": no beat is produced, flatline is
//   held high and the code is re-sampled on every tick until it leaves 3.
//   When undefined, code 3 beats at PERIOD_SLEEP and flatline is tied low.

module heartbeat_pulse_gen #(
  parameter int unsigned PERIOD_FAST   = 8,
  parameter int unsigned PERIOD_NORMAL = 16,
  parameter int unsigned PERIOD_SLOW   = 32,
  parameter int unsigned PERIOD_SLEEP  = 64,
  parameter int unsigned LUB_LEN       = 2,
  parameter int unsigned GAP_LEN       = 1,
  parameter int unsigned DUB_LEN       = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic [1:0] heartbeat,
  output logic       beat_o,
  output logic       beat_start,
  output logic [1:0] rate_o,
  output logic [7:0] beat_count,
  output logic       flatline
);

  typedef enum logic [2:0] {
    StIdle,
    StLub,
    StGap,
    StDub,
    StRest
  } state_e;

  // Terminal counts for each fixed-length phase (length - 1).
  localparam int unsigned BurstLen = LUB_LEN + GAP_LEN + DUB_LEN;
  localparam logic [7:0]  LubLast  = 8'(LUB_LEN - 1);
  localparam logic [7:0]  GapLast  = 8'(GAP_LEN - 1);
  localparam logic [7:0]  DubLast  = 8'(DUB_LEN - 1);

  localparam logic [1:0]  CodeSleep = 2'd3;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] rate_q, rate_d;
  logic [7:0] count_q, count_d;
  logic       beat_q, beat_d;
  logic       start_q, start_d;

  logic [7:0] period;
  logic [7:0] rest_last;
  logic       launch;

`ifdef HEARTBEAT_FLATLINE_EN
  logic       flat_q, flat_d;
`endif

  // Select the beat period from the code latched for the current beat.
  always_comb begin
    period = 8'(PERIOD_NORMAL);
    unique case (rate_q)
      2'd0: period = 8'(PERIOD_FAST);
      2'd1: period = 8'(PERIOD_NORMAL);
      2'd2: period = 8'(PERIOD_SLOW);
`ifdef HEARTBEAT_FLATLINE_EN
      // Code 3 never runs a timed REST when flatline is enabled.
      2'd3: period = 8'(PERIOD_SLOW);
`else
      2'd3: period = 8'(PERIOD_SLEEP);
`endif
      default: period = 8'(PERIOD_NORMAL);
    endcase
    rest_last = period - 8'(BurstLen) - 8'd1;
  end

  // Next-state logic: phase sequencing, beat launch and bookkeeping.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rate_d  = rate_q;
    count_d = count_q;
    start_d = 1'b0;
    launch  = 1'b0;
`ifdef HEARTBEAT_FLATLINE_EN
    flat_d  = flat_q;
`endif

    if (tick) begin
      unique case (state_q)
        StIdle: begin
          launch = 1'b1;
        end
        StLub: begin
          if (cnt_q == LubLast) begin
            state_d = StGap;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        StGap: begin
          if (cnt_q == GapLast) begin
            state_d = StDub;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        StDub: begin
          if (cnt_q == DubLast) begin
            state_d = StRest;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        StRest: begin
`ifdef HEARTBEAT_FLATLINE_EN
          if (flat_q) begin
            // Flatlined: leave as soon as the code is no longer sleep.
            launch = (heartbeat != CodeSleep);
          end else
`endif
          if (cnt_q == rest_last) begin
            launch = 1'b1;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = 8'd0;
        end
      endcase

      // Beat boundary: latch the code and start a new beat.
      if (launch) begin
        cnt_d  = 8'd0;
        rate_d = heartbeat;
`ifdef HEARTBEAT_FLATLINE_EN
        if (heartbeat == CodeSleep) begin
          state_d = StRest;
          flat_d  = 1'b1;
        end else begin
          state_d = StLub;
          flat_d  = 1'b0;
          start_d = 1'b1;
          count_d = count_q + 8'd1;
        end
`else
        state_d = StLub;
        start_d = 1'b1;
        count_d = count_q + 8'd1;
`endif
      end
    end

    // Registered waveform follows the state being entered.
    beat_d = (state_d == StLub) || (state_d == StDub);
  end

  // State and output registers; async reset clears the waveform at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 8'd0;
      rate_q  <= 2'd0;
      count_q <= 8'd0;
      beat_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rate_q  <= rate_d;
      count_q <= count_d;
      beat_q  <= beat_d;
      start_q <= start_d;
    end
  end

`ifdef HEARTBEAT_FLATLINE_EN
  // Flatline flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flat_q <= 1'b0;
    end else begin
      flat_q <= flat_d;
    end
  end

  assign flatline = flat_q;
`else
  assign flatline = 1'b0;
`endif

  assign beat_o     = beat_q;
  assign beat_start = start_q;
  assign rate_o     = rate_q;
  assign beat_count = count_q;

endmodule

// File: tb/tb_heartbeat_pulse_gen.sv
// Scoreboard bench for heartbeat_pulse_gen: the stimulus pushes the expected
// beat_start events (cycle, rate, count); a monitor pops one per observed
// beat_start and also checks beat_o against the lub-dub shape every cycle.

module tb_heartbeat_pulse_gen;

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic [1:0] heartbeat;
  logic       beat_o;
  logic       beat_start;
  logic [1:0] rate_o;
  logic [7:0] beat_count;
  logic       flatline;

  typedef struct {
    int cyc;
    int rate;
    int count;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   div      = 1;
  int   ph       = 0;

  heartbeat_pulse_gen dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .heartbeat  (heartbeat),
    .beat_o     (beat_o),
    .beat_start (beat_start),
    .rate_o     (rate_o),
    .beat_count (beat_count),
    .flatline   (flatline)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1);
  end

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (cyc=%0d)", nm, got, exp, cyc);
    end
  endtask

  function automatic void push(input int c, input int r, input int n);
    exp_t e;
    e.cyc   = c;
    e.rate  = r;
    e.count = n;
    sb.push_back(e);
  endfunction

  // Tick for the next rising edge: one tick every div clocks.
  task automatic drive_tick();
    tick = (ph == 0);
    ph   = (ph + 1) % div;
  endtask

  task automatic step();
    @(negedge clk);
    drive_tick();
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) step();
  endtask

  // Assert reset, check cleared outputs, release on a falling edge.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    tick  = 1'b0;
    #1;
    chk("rst_beat_o", int'(beat_o), 0);
    chk("rst_beat_start", int'(beat_start), 0);
    chk("rst_rate_o", int'(rate_o), 0);
    chk("rst_beat_count", int'(beat_count), 0);
    chk("rst_flatline", int'(flatline), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: scoreboard pop on beat_start, waveform shape on every cycle.
  initial begin
    int  last;
    bit  valid;
    int  q;
    int  expo;
    exp_t e;
    last  = 0;
    valid = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        valid = 1'b0;
      end else begin
        if (beat_start) begin
          if (sb.size() == 0) begin
            chk("unexpected_beat_start", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("beat_cyc", cyc, e.cyc);
            chk("beat_rate", int'(rate_o), e.rate);
            chk("beat_count", int'(beat_count), e.count);
          end
          last  = cyc;
          valid = 1'b1;
        end
        q    = (cyc - last) / div;
        expo = (valid && (q == 0 || q == 1 || q == 3 || q == 4)) ? 1 : 0;
        chk("beat_o_shape", int'(beat_o), expo);
      end
    end
  end

  initial begin
    int c;
    int d;
    int e;
    int f;
    rst_n     = 1'b1;
    tick      = 1'b0;
    heartbeat = 2'd1;
    #1 rst_n  = 1'b0;

    // Normal rate, then fast, slow and sleep with mid-beat code changes.
    do_reset();
    c = cyc;
    heartbeat = 2'd1;
    div = 1;
    ph  = 0;
    drive_tick();
    for (int k = 0; k < 4; k++) push(c + 1 + 16 * k, 1, k + 1);
    wait_until(c + 52);
    heartbeat = 2'd0;
    push(c + 65, 0, 5);
    push(c + 73, 0, 6);
    push(c + 81, 0, 7);
    wait_until(c + 82);
    heartbeat = 2'd2;
    push(c + 89, 2, 8);
    push(c + 121, 2, 9);
    wait_until(c + 122);
    heartbeat = 2'd3;
`ifdef HEARTBEAT_FLATLINE_EN
    wait_until(c + 158);
    chk("flat_high", int'(flatline), 1);
    chk("flat_beat_o", int'(beat_o), 0);
    chk("flat_count_hold", int'(beat_count), 9);
    heartbeat = 2'd1;
    push(c + 159, 1, 10);
    push(c + 175, 1, 11);
    wait_until(c + 160);
    chk("flat_low", int'(flatline), 0);
`else
    push(c + 153, 3, 10);
    push(c + 217, 3, 11);
    wait_until(c + 160);
    chk("flatline_tied_low", int'(flatline), 0);
`endif
    wait_until(c + 222);
    chk("sb_drain_rates", sb.size(), 0);

    // Reset during DUB clears the waveform and count immediately.
    do_reset();
    d = cyc;
    heartbeat = 2'd1;
    div = 1;
    ph  = 0;
    drive_tick();
    push(d + 1, 1, 1);
    wait_until(d + 4);
    chk("pre_rst_dub_beat_o", int'(beat_o), 1);
    rst_n = 1'b0;
    tick  = 1'b0;
    #1;
    chk("mid_rst_beat_o", int'(beat_o), 0);
    chk("mid_rst_beat_count", int'(beat_count), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Tick every 4th clock: 64-clk spacing, 8-clk pulses, frozen in between.
    e   = cyc;
    div = 4;
    ph  = 0;
    drive_tick();
    push(e + 1, 1, 1);
    push(e + 65, 1, 2);
    push(e + 129, 1, 3);
    wait_until(e + 140);
    chk("sb_drain_slowtick", sb.size(), 0);

    // 257 fast beats: count wraps 255 -> 0 -> 1.
    do_reset();
    f = cyc;
    heartbeat = 2'd0;
    div = 1;
    ph  = 0;
    drive_tick();
    for (int k = 0; k <= 256; k++) push(f + 1 + 8 * k, 0, (k + 1) % 256);
    wait_until(f + 1 + 8 * 256 + 3);
    chk("wrap_final_count", int'(beat_count), 1);
    chk("sb_drain_wrap", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
